// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus start/done sequencer feeding a UART transmitter, one byte per start pulse.
// Optional WAIT_DONE watchdog and sticky o_timeout port are enabled by defining UART_TX_FEEDER_TIMEOUT_EN.
module uart_tx_feeder #(
    parameter int NB_DATA        = 8,
    parameter int LOG2_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic [NB_DATA-1:0]    i_wr_data,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [LOG2_DEPTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_busy
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    output logic                  o_timeout
`endif
);

    localparam int MEM_DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH = {1'b1, {LOG2_DEPTH{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_START = 3'b010,
        ST_WAIT  = 3'b100
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_pop;
    logic                      w_wr_accept;
    logic [LOG2_DEPTH:0]       r_count;
    logic [LOG2_DEPTH-1:0]     r_wr_ptr;
    logic [LOG2_DEPTH-1:0]     r_rd_ptr;
    logic [NB_DATA-1:0]        r_mem [MEM_DEPTH];
    logic [NB_DATA-1:0]        r_tx_data;
    logic                      r_tx_start;
    logic                      r_overflow;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    logic [NB_TIMEOUT-1:0]     r_to_cnt;
    logic                      r_timeout;
    logic                      w_to_event;
`endif

    // A pop frees a slot on the same edge, so a full FIFO still accepts a write then.
    assign w_wr_accept = i_wr && ((r_count != DEPTH) || w_pop);

    // Next-state and pop decode.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        w_to_event   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_count != {(LOG2_DEPTH+1){1'b0}}) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    w_state_next = ST_IDLE;
                end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_state_next = ST_IDLE;
                    w_to_event   = 1'b1;
                end
`endif
                else begin
                    w_state_next = ST_WAIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start pulse and the byte handed to the transmitter, captured at the pop.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= {NB_DATA{1'b0}};
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Storage array: not reset, contents are only meaningful between the pointers.
    always_ff @(posedge i_clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr   <= {LOG2_DEPTH{1'b0}};
            r_rd_ptr   <= {LOG2_DEPTH{1'b0}};
            r_count    <= {(LOG2_DEPTH+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_wr && !w_wr_accept) begin
                r_overflow <= 1'b1;
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Watchdog: held at zero outside WAIT_DONE, so every entry starts a fresh count.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_to_cnt  <= {NB_TIMEOUT{1'b0}};
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_WAIT) begin
                r_to_cnt <= {NB_TIMEOUT{1'b0}};
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_event) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`endif

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_count    = r_count;
    assign o_full     = (r_count == DEPTH);
    assign o_empty    = (r_count == {(LOG2_DEPTH+1){1'b0}});
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: writes push expected bytes, a monitor checks each start pulse.
module tb_uart_tx_feeder;

    logic       i_clock;
    logic       i_reset;
    logic       i_wr;
    logic [7:0] i_wr_data;
    logic       i_tx_done;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_busy;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic       o_timeout;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q[$];
    logic [7:0] held;
    logic       prev_start = 1'b0;

    uart_tx_feeder #(
        .NB_DATA        (8),
        .LOG2_DEPTH     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_wr_data  (i_wr_data),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        ,
        .o_timeout  (o_timeout)
`endif
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Monitor: every start must carry the oldest expected byte, and data must hold while busy.
    always @(negedge i_clock) begin
        if (i_reset) begin
            if (o_tx_start) begin
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL start_width: start high on consecutive samples, got 2+ cycles expected 1");
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: got start with data %02h expected no start", o_tx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb_q.pop_front();
                    if (o_tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL start_data: got %02h expected %02h", o_tx_data, exp_b);
                    end
                end
                held = o_tx_data;
            end else if (o_busy) begin
                checks++;
                if (o_tx_data !== held) begin
                    errors++;
                    $display("FAIL data_stable: got %02h expected %02h", o_tx_data, held);
                end
            end
        end
        prev_start = o_tx_start;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accepted);
        i_wr      = 1'b1;
        i_wr_data = d;
        if (accepted) sb_q.push_back(d);
        @(posedge i_clock);
        #1;
        i_wr      = 1'b0;
    endtask

    task automatic done_pulse();
        i_tx_done = 1'b1;
        @(posedge i_clock);
        #1;
        i_tx_done = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"},    {31'd0, o_tx_start}, 32'd0);
        chk({tag, "_data"},     {24'd0, o_tx_data},  32'd0);
        chk({tag, "_overflow"}, {31'd0, o_overflow}, 32'd0);
        chk({tag, "_busy"},     {31'd0, o_busy},     32'd0);
        chk({tag, "_empty"},    {31'd0, o_empty},    32'd1);
        chk({tag, "_full"},     {31'd0, o_full},     32'd0);
        chk({tag, "_count"},    {27'd0, o_count},    32'd0);
    endtask

    initial begin
        i_reset   = 1'b0;
        i_wr      = 1'b0;
        i_wr_data = 8'h00;
        i_tx_done = 1'b0;
        repeat (3) @(negedge i_clock);
        chk_reset_vals("reset");
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;

        // Single byte: count=1 after write edge, start one edge later for one cycle.
        @(negedge i_clock);
        write_byte(8'hA5, 1'b1);
        @(negedge i_clock);
        chk("single_count_after_write", {27'd0, o_count}, 32'd1);
        chk("single_no_start_yet", {31'd0, o_tx_start}, 32'd0);
        @(negedge i_clock);
        chk("single_start", {31'd0, o_tx_start}, 32'd1);
        chk("single_busy", {31'd0, o_busy}, 32'd1);
        chk("single_count_popped", {27'd0, o_count}, 32'd0);
        @(negedge i_clock);
        chk("single_start_low", {31'd0, o_tx_start}, 32'd0);
        chk("single_busy_wait", {31'd0, o_busy}, 32'd1);
        done_pulse();
        @(negedge i_clock);
        chk("single_idle", {31'd0, o_busy}, 32'd0);
        chk("single_empty", {31'd0, o_empty}, 32'd1);

        // Burst of 5: first byte pops during the burst, leaving 4 queued.
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        @(negedge i_clock);
        chk("burst_count_peak", {27'd0, o_count}, 32'd4);
        for (int k = 0; k < 5; k++) begin
            repeat (20) @(negedge i_clock);
            done_pulse();
            @(negedge i_clock);
            chk("burst_gap_no_start", {31'd0, o_tx_start}, 32'd0);
            @(negedge i_clock);
            if (k < 4) chk("burst_start_after_done", {31'd0, o_tx_start}, 32'd1);
            else       chk("burst_idle_at_end", {31'd0, o_busy}, 32'd0);
        end
        chk("burst_empty", {31'd0, o_empty}, 32'd1);

        // Fill to 16 while stalled, write on the pop edge, then overflow on the 17th.
        write_byte(8'h00, 1'b1);
        repeat (3) @(negedge i_clock);
        for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i), 1'b1);
        @(negedge i_clock);
        chk("full_count", {27'd0, o_count}, 32'd16);
        chk("full_flag", {31'd0, o_full}, 32'd1);
        chk("full_no_overflow", {31'd0, o_overflow}, 32'd0);
        done_pulse();
        write_byte(8'h20, 1'b1);
        @(negedge i_clock);
        chk("pop_write_count", {27'd0, o_count}, 32'd16);
        chk("pop_write_full", {31'd0, o_full}, 32'd1);
        chk("pop_write_no_overflow", {31'd0, o_overflow}, 32'd0);
        write_byte(8'h21, 1'b0);
        @(negedge i_clock);
        chk("drop_overflow", {31'd0, o_overflow}, 32'd1);
        chk("drop_count", {27'd0, o_count}, 32'd16);
        repeat (17) begin
            repeat (4) @(negedge i_clock);
            done_pulse();
        end
        repeat (3) @(negedge i_clock);
        chk("drain_count", {27'd0, o_count}, 32'd0);
        chk("drain_empty", {31'd0, o_empty}, 32'd1);
        chk("drain_busy", {31'd0, o_busy}, 32'd0);
        chk("drain_sb_left", sb_q.size(), 32'd0);
        chk("drain_overflow_sticky", {31'd0, o_overflow}, 32'd1);

        // Asynchronous reset mid-WAIT_DONE with 3 bytes queued.
        for (int i = 0; i < 4; i++) write_byte(8'h31 + 8'(i), 1'b1);
        repeat (3) @(negedge i_clock);
        chk("pre_reset_count", {27'd0, o_count}, 32'd3);
        #2;
        i_reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        sb_q.delete();
        @(negedge i_clock);
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        @(negedge i_clock);
        done_pulse();
        repeat (5) @(negedge i_clock);
        chk("stray_done_busy", {31'd0, o_busy}, 32'd0);
        chk("stray_done_empty", {31'd0, o_empty}, 32'd1);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // Watchdog: 50 WAIT_DONE cycles without done abandons the byte.
        write_byte(8'h41, 1'b1);
        write_byte(8'h42, 1'b1);
        @(negedge i_clock);
        chk("to_first_start", {31'd0, o_tx_start}, 32'd1);
        repeat (50) @(negedge i_clock);
        chk("to_still_busy", {31'd0, o_busy}, 32'd1);
        chk("to_not_yet", {31'd0, o_timeout}, 32'd0);
        @(negedge i_clock);
        chk("to_idle", {31'd0, o_busy}, 32'd0);
        chk("to_flag", {31'd0, o_timeout}, 32'd1);
        @(negedge i_clock);
        chk("to_next_start", {31'd0, o_tx_start}, 32'd1);
        done_pulse();
        repeat (3) @(negedge i_clock);
        chk("to_empty", {31'd0, o_empty}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and start sequencer directly upstream of the UART transmitter.
- Accepts bytes from a producer (ALU/interface logic) into a circular FIFO.
- Presents the bytes one at a time to the transmitter with a one-cycle start pulse, then waits for the transmitter's done pulse before issuing the next byte.
- Decouples producer bursts from the serial line rate.

Parameters:
- NB_DATA, 8, width of each byte/word.
- LOG2_DEPTH, 4, log2 of FIFO depth (depth = 2**LOG2_DEPTH = 16).
- TIMEOUT_CYCLES, 2000000, maximum clocks spent in WAIT_DONE; used only with the optional feature.
- NB_TIMEOUT, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
- i_clock  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_wr  in  1  write strobe; one byte per cycle when high.
- i_wr_data  in  NB_DATA  byte to enqueue.
- i_tx_done  in  1  one-cycle pulse from the transmitter: stop bit finished.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- o_tx_data  out  NB_DATA  byte for the transmitter; registered and stable from the start pulse until done.
- o_full  out  1  count == 2**LOG2_DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  LOG2_DEPTH+1  bytes currently stored, not counting the byte in flight.
- o_overflow  out  1  sticky: a write was dropped.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (i_reset low, asynchronous):
  - Read/write pointers and count go to 0.
  - FSM goes to IDLE.
  - o_tx_start=0, o_tx_data=0, o_overflow=0, o_busy=0, o_empty=1, o_full=0.
  - Storage array is not reset; its contents are discarded logically.
  - Reset mid-transfer abandons the in-flight byte. No done is expected afterwards; a stray i_tx_done is ignored in IDLE.
- Write side:
  - A byte is stored at the write pointer when i_wr=1 and (count < depth, or a pop occurs in the same cycle).
  - Otherwise the byte is dropped and o_overflow is set; it stays set until reset.
  - Pointers wrap modulo depth.
- Pop:
  - Occurs on the cycle the FSM leaves IDLE.
  - The head byte is registered into o_tx_data and the read pointer advances.
- Count update:
  - Write only: +1.
  - Pop only: -1.
  - Both: unchanged.
- FSM states: IDLE, START, WAIT_DONE (one-hot).
  - IDLE: if registered count != 0 -> pop, go to START. o_tx_start is registered high for exactly the START cycle.
  - START: o_tx_start=1 for one cycle -> WAIT_DONE unconditionally.
  - WAIT_DONE: o_tx_start=0, o_tx_data held. On i_tx_done=1 -> IDLE.
  - i_tx_done is ignored in IDLE and START.
- Latency and throughput:
  - Byte written at edge N into an empty, idle block: count=1 after N, pop at edge N+1, o_tx_start high between edges N+1 and N+2.
  - After i_tx_done is sampled at edge M with count != 0: next pop at edge M+1, start at M+1..M+2.
  - Minimum gap: 2 cycles from done to the next start.
- o_busy = (state != IDLE).
- o_full and o_empty derive from the registered count.

Optional Feature:
- Macro: UART_TX_FEEDER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT_DONE and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES without i_tx_done, the FSM returns to IDLE and the byte is abandoned.
  - Extra output port o_timeout (1 bit) is sticky, set on the event and cleared only by reset.
- Not defined:
  - No counter and no o_timeout port.
  - WAIT_DONE waits indefinitely.

Test Plan:
- Reset, then write 0xA5 once -> o_tx_start pulses exactly one cycle, 2 cycles after the write edge, with o_tx_data=0xA5; o_busy=1 until the done pulse; afterwards o_empty=1, o_count=0.
- Burst-write 0x01..0x05 on consecutive cycles while done is held off -> o_count peaks at 4. Then issue a done pulse every 20 cycles -> starts appear in order 0x01..0x05, each 2 cycles after the previous done; o_tx_data is stable between start and done.
- Write 17 bytes while WAIT_DONE is stalled on the first byte -> o_full=1 after 16 stored bytes, the 17th byte is dropped, o_overflow=1. Subsequent sequence is 1..16 with no corruption, pointers wrap correctly.
- Full FIFO with i_wr=1 on the same cycle as the pop -> write accepted, o_count stays 16, o_overflow stays 0.
- Assert i_reset=0 asynchronously mid-WAIT_DONE with 3 bytes queued -> all outputs go to reset values immediately with no clock edge; a later i_tx_done produces no start.
- With UART_TX_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=50, withhold done -> o_timeout=1 after 50 WAIT_DONE cycles, FSM returns to IDLE, and the next queued byte starts 2 cycles later.
